// File: rtl/register_file_read.sv
// Decode-stage 32x32 register file with write-first bypass, load-use hazard
// detection and the decode->execute operand pipeline register.
module register_file_read #(
  parameter int                 DATA_W       = 32,
  parameter logic [DATA_W-1:0]  RF_RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              keep,
  input  logic              nop,
  input  logic [4:0]        rs_addr,
  input  logic [4:0]        rt_addr,
  input  logic              rs_used,
  input  logic              rt_used,
  input  logic              Regwrite,
  input  logic [4:0]        write_reg_address,
  input  logic [DATA_W-1:0] write_reg_data,
  input  logic              ex_load_pype2,
  input  logic [4:0]        ex_wreg_pype2,
  output logic [DATA_W-1:0] rs_data_pype2,
  output logic [DATA_W-1:0] rt_data_pype2,
  output logic [4:0]        rs_addr_pype2,
  output logic [4:0]        rt_addr_pype2,
  output logic              valid_pype2,
  output logic              load_use_stall
);

  logic [DATA_W-1:0] regs_q [32];
  logic [DATA_W-1:0] regs_d [32];
  logic [DATA_W-1:0] rd_rs, rd_rt;

  logic [DATA_W-1:0] rs_data_q, rs_data_d;
  logic [DATA_W-1:0] rt_data_q, rt_data_d;
  logic [4:0]        rs_addr_q, rs_addr_d;
  logic [4:0]        rt_addr_q, rt_addr_d;
  logic              valid_q, valid_d;

  always_comb begin
    regs_d = regs_q;
    if (Regwrite && (write_reg_address != 5'd0))
      regs_d[write_reg_address] = write_reg_data;
    regs_d[0] = '0;
  end

  // Write-first: a same-cycle writeback to the read address wins over storage.
  always_comb begin
    rd_rs = regs_q[rs_addr];
    if (rs_addr == 5'd0)
      rd_rs = '0;
    else if (Regwrite && (write_reg_address == rs_addr))
      rd_rs = write_reg_data;

    rd_rt = regs_q[rt_addr];
    if (rt_addr == 5'd0)
      rd_rt = '0;
    else if (Regwrite && (write_reg_address == rt_addr))
      rd_rt = write_reg_data;
  end

  always_comb begin
    load_use_stall = ex_load_pype2 && (ex_wreg_pype2 != 5'd0) &&
                     ((rs_used && (rs_addr == ex_wreg_pype2)) ||
                      (rt_used && (rt_addr == ex_wreg_pype2)));
  end

  // Bubbles carry zero addresses so downstream forwarding never matches them.
  always_comb begin
    rs_data_d = rs_data_q;
    rt_data_d = rt_data_q;
    rs_addr_d = rs_addr_q;
    rt_addr_d = rt_addr_q;
    valid_d   = valid_q;
    if (!keep) begin
      if (nop || load_use_stall) begin
        rs_data_d = '0;
        rt_data_d = '0;
        rs_addr_d = 5'd0;
        rt_addr_d = 5'd0;
        valid_d   = 1'b0;
      end else begin
        rs_data_d = rd_rs;
        rt_data_d = rd_rt;
        rs_addr_d = rs_addr;
        rt_addr_d = rt_addr;
        valid_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++)
        regs_q[i] <= (i == 0) ? '0 : RF_RESET_VAL;
      rs_data_q <= '0;
      rt_data_q <= '0;
      rs_addr_q <= 5'd0;
      rt_addr_q <= 5'd0;
      valid_q   <= 1'b0;
    end else begin
      regs_q    <= regs_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      rs_addr_q <= rs_addr_d;
      rt_addr_q <= rt_addr_d;
      valid_q   <= valid_d;
    end
  end

  assign rs_data_pype2 = rs_data_q;
  assign rt_data_pype2 = rt_data_q;
  assign rs_addr_pype2 = rs_addr_q;
  assign rt_addr_pype2 = rt_addr_q;
  assign valid_pype2   = valid_q;

endmodule

// File: tb/tb_register_file_read.sv
// Scoreboard bench for register_file_read: directed scenarios plus randomized
// traffic checked against an array-based architectural model.
module tb_register_file_read;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        keep = 1'b0, nop = 1'b0;
  logic [4:0]  rs_addr = '0, rt_addr = '0;
  logic        rs_used = 1'b0, rt_used = 1'b0;
  logic        Regwrite = 1'b0;
  logic [4:0]  write_reg_address = '0;
  logic [31:0] write_reg_data = '0;
  logic        ex_load_pype2 = 1'b0;
  logic [4:0]  ex_wreg_pype2 = '0;
  logic [31:0] rs_data_pype2, rt_data_pype2;
  logic [4:0]  rs_addr_pype2, rt_addr_pype2;
  logic        valid_pype2, load_use_stall;

  register_file_read #(.DATA_W(32), .RF_RESET_VAL(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .keep(keep), .nop(nop),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_used(rs_used), .rt_used(rt_used),
    .Regwrite(Regwrite), .write_reg_address(write_reg_address),
    .write_reg_data(write_reg_data), .ex_load_pype2(ex_load_pype2),
    .ex_wreg_pype2(ex_wreg_pype2), .rs_data_pype2(rs_data_pype2),
    .rt_data_pype2(rt_data_pype2), .rs_addr_pype2(rs_addr_pype2),
    .rt_addr_pype2(rt_addr_pype2), .valid_pype2(valid_pype2),
    .load_use_stall(load_use_stall)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] rs_d;
    logic [31:0] rt_d;
    logic [4:0]  rs_a;
    logic [4:0]  rt_a;
    logic        v;
  } exp_t;

  exp_t        expq[$];
  exp_t        cur;
  logic [31:0] mregs [32];
  int          n_vec = 0;
  int          n_miss = 0;

  function automatic logic [31:0] model_read(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (Regwrite && write_reg_address == a) return write_reg_data;
    return mregs[a];
  endfunction

  function automatic logic model_stall();
    return ex_load_pype2 && ex_wreg_pype2 != 0 &&
           ((rs_used && rs_addr == ex_wreg_pype2) || (rt_used && rt_addr == ex_wreg_pype2));
  endfunction

  // Monitor: the pipeline register presents a new state after every edge.
  always @(posedge clk) begin
    #1;
    if (expq.size() > 0) begin
      exp_t e;
      exp_t a;
      e = expq.pop_front();
      a = '{rs_data_pype2, rt_data_pype2, rs_addr_pype2, rt_addr_pype2, valid_pype2};
      n_vec++;
      if (a !== e) begin
        n_miss++;
        $display("FAIL pipe_reg: got rs=%h rt=%h rsa=%0d rta=%0d v=%b, want rs=%h rt=%h rsa=%0d rta=%0d v=%b",
                 a.rs_d, a.rt_d, a.rs_a, a.rt_a, a.v, e.rs_d, e.rt_d, e.rs_a, e.rt_a, e.v);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Inputs already set by caller; applied from the negedge through one posedge.
  task automatic apply();
    logic st;
    #1;
    st = model_stall();
    check("load_use_stall", {31'b0, load_use_stall}, {31'b0, st});
    if (!keep) begin
      if (nop || st) cur = '0;
      else cur = '{model_read(rs_addr), model_read(rt_addr), rs_addr, rt_addr, 1'b1};
    end
    expq.push_back(cur);
    @(posedge clk);
    if (Regwrite && write_reg_address != 0) mregs[write_reg_address] = write_reg_data;
    @(negedge clk);
  endtask

  task automatic idle();
    keep = 0; nop = 0; Regwrite = 0; ex_load_pype2 = 0; ex_wreg_pype2 = 0;
    rs_used = 0; rt_used = 0; rs_addr = 0; rt_addr = 0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
    cur = '0;
    expq.delete();
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1;

    // Write r7, then read it
    idle(); Regwrite = 1; write_reg_address = 7; write_reg_data = 32'hDEAD_BEEF; apply();
    idle(); rs_addr = 7; rs_used = 1; apply();
    // Bypass on rt, r0 discard
    idle(); Regwrite = 1; write_reg_address = 3; write_reg_data = 32'h1234_5678;
    rt_addr = 3; rt_used = 1; rs_addr = 7; apply();
    idle(); Regwrite = 1; write_reg_address = 0; write_reg_data = 32'hFFFF_FFFF;
    rs_addr = 0; rt_addr = 3; apply();
    idle(); rs_addr = 0; rt_addr = 0; apply();
    // Load-use cases
    idle(); ex_load_pype2 = 1; ex_wreg_pype2 = 9; rs_addr = 9; rs_used = 1; rt_addr = 3; apply();
    idle(); ex_load_pype2 = 1; ex_wreg_pype2 = 9; rs_addr = 9; rs_used = 0; rt_addr = 3; apply();
    idle(); ex_load_pype2 = 1; ex_wreg_pype2 = 0; rs_addr = 0; rs_used = 1; rt_addr = 7; apply();
    idle(); ex_load_pype2 = 1; ex_wreg_pype2 = 3; rt_addr = 3; rt_used = 1; rs_addr = 7; apply();
    // keep for 3 cycles while writing r4, with a stall also pending
    idle(); rs_addr = 7; rt_addr = 3; apply();
    for (int i = 0; i < 3; i++) begin
      idle(); keep = 1; Regwrite = 1; write_reg_address = 4; write_reg_data = 32'hA5A5_A5A5;
      rs_addr = 4; rt_addr = 4; rs_used = 1; ex_load_pype2 = (i == 1); ex_wreg_pype2 = 4;
      apply();
    end
    idle(); rs_addr = 4; rt_addr = 7; apply();
    // nop with valid reads
    idle(); nop = 1; rs_addr = 4; rt_addr = 7; rs_used = 1; rt_used = 1; apply();
    idle(); rs_addr = 4; rt_addr = 3; apply();

    // Randomized traffic, small address range for frequent collisions
    for (int n = 0; n < 400; n++) begin
      idle();
      keep = ($urandom_range(0, 99) < 15);
      nop = ($urandom_range(0, 99) < 10);
      Regwrite = $urandom_range(0, 1);
      write_reg_address = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      write_reg_data = $urandom;
      rs_addr = 5'($urandom_range(0, 7));
      rt_addr = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      rs_used = $urandom_range(0, 1);
      rt_used = $urandom_range(0, 1);
      ex_load_pype2 = ($urandom_range(0, 99) < 30);
      ex_wreg_pype2 = 5'($urandom_range(0, 7));
      apply();
    end

    // Mid-cycle asynchronous reset with nonzero outputs
    idle(); rs_addr = 7; rt_addr = 3; apply();
    @(posedge clk);
    #3;
    check("pre_reset_valid", {31'b0, valid_pype2}, 32'h1);
    rst = 0;
    #1;
    check("rst_rs_data", rs_data_pype2, 32'h0);
    check("rst_rt_data", rt_data_pype2, 32'h0);
    check("rst_addrs", {22'b0, rs_addr_pype2, rt_addr_pype2}, 32'h0);
    check("rst_valid", {31'b0, valid_pype2}, 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1;
    idle(); rs_addr = 5; rt_addr = 7; apply();
    idle(); apply();

    @(posedge clk);
    #2;
    check("scoreboard_drained", expq.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/register_file_read.md
# register_file_read

Decode-stage register file and operand-read pipeline register for the 5-stage core: the consumer of the writeback stage's register write port. Holds 32×32-bit architectural registers, takes one write per cycle from writeback, serves two combinational read ports with write-first bypass, and registers the operands into the decode→execute pipeline register (`_pype2`). Also detects load-use hazards against the instruction in execute and injects a bubble.

## Interface
- RF_RESET_VAL, 32'h0000_0000, value loaded into r1..r31 on reset; r0 is always 0.
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- keep  in  1  freeze the pipeline register (global stall); register-file writes still occur.
- nop  in  1  load a bubble into the pipeline register this cycle.
- rs_addr  in  5  source register A address (decode).
- rt_addr  in  5  source register B address (decode).
- rs_used / rt_used  in  1 each  the decoded instruction actually reads rs / rt.
- Regwrite  in  1  active-high write enable from writeback.
- write_reg_address  in  5  write address from writeback.
- write_reg_data  in  32  write data from writeback.
- ex_load_pype2  in  1  instruction now in execute is a load.
- ex_wreg_pype2  in  5  destination register of that instruction.
- rs_data_pype2 / rt_data_pype2  out  32 each  registered operands.
- rs_addr_pype2 / rt_addr_pype2  out  5 each  registered source addresses (for forwarding).
- valid_pype2  out  1  pipeline register holds a real instruction.
- load_use_stall  out  1  combinational; decode must hold PC/IF-ID this cycle.

## Operation
- Storage: regs[0..31]; rising edge with Regwrite=1 and write_reg_address≠0 writes write_reg_data. Writes to r0 are discarded; reading r0 always returns 0.
- Read (combinational): rd_x = 0 if addr_x==0; else write_reg_data if Regwrite && write_reg_address==addr_x (write-first bypass); else regs[addr_x].
- load_use_stall = ex_load_pype2 && ex_wreg_pype2≠0 && ((rs_used && rs_addr==ex_wreg_pype2) || (rt_used && rt_addr==ex_wreg_pype2)). Not gated by keep or nop.
- Pipeline register update, priority high→low:
  1. rst=0: all outputs 0, regs r1..r31 = RF_RESET_VAL.
  2. keep=1: all `_pype2` outputs hold.
  3. nop=1 or load_use_stall=1: bubble; valid_pype2=0, data and address outputs 0.
  4. else: rs/rt_data_pype2 ← rd_rs/rd_rt, addresses ← rs/rt_addr, valid_pype2 ← 1.
- keep=1 does not block register-file writes: writeback keeps retiring.
- A bubble's addresses are 0 so downstream forwarding never matches it.

## Timing
- Write latency: data written at edge N is in regs after N; a same-cycle read before N gets it via bypass.
- Read-to-output latency: 1 cycle (operands visible on `_pype2` after the next edge).
- load_use_stall is asserted in the same cycle as the conflicting decode; it produces exactly one bubble per stalled cycle. Once the load advances, ex_load_pype2 drops and the next edge captures real operands.
- Reset asserts asynchronously mid-cycle: outputs go to 0 immediately. On release, the first edge performs a normal update.
- Simultaneous write and read of the same nonzero address: the read returns the new data.
- Simultaneous keep and load_use_stall: keep wins, outputs hold, stall still asserted.

## Test plan
- Reset: drive rst=0 mid-cycle with outputs nonzero -> all outputs 0 immediately; after release read r5 -> 0 (RF_RESET_VAL=0).
- Write/read: write r7=32'hDEAD_BEEF, next cycle rs_addr=7 -> rs_data_pype2=32'hDEAD_BEEF and valid_pype2=1 one edge later.
- Bypass and r0: in the same cycle write r3=32'h1234_5678 and read rt_addr=3 -> rt_data_pype2=32'h1234_5678. Write r0=32'hFFFF_FFFF, read r0 -> 0.
- Load-use: ex_load_pype2=1, ex_wreg_pype2=9, rs_addr=9, rs_used=1 -> load_use_stall=1 and next valid_pype2=0. Same case with rs_used=0 -> no stall. Case with ex_wreg_pype2=0 -> no stall.
- keep vs writes: keep=1 for 3 cycles while writing r4=32'hA5A5_A5A5 -> `_pype2` outputs unchanged. After keep drops, reading r4 -> 32'hA5A5_A5A5.
- nop: nop=1 with valid reads -> valid_pype2=0, rs/rt_data_pype2=0, addresses 0.
